// File: rtl/ca2_preimage_finder_if.sv
// Handshake and result bundle for the CA preimage finder coprocessor.
// The slave modport is the finder; the master modport is the requesting logic.
interface ca2_preimage_finder_if #(
    parameter int N_CELLS = 8
);
    logic               i_start;
    logic [N_CELLS-1:0] i_target;
    logic [3:0]         i_rule;
    logic               o_busy;
    logic               o_done;
    logic               o_found;
    logic [N_CELLS-1:0] o_preimage;
    logic [N_CELLS:0]   o_count;

    modport slave (
        input  i_start, i_target, i_rule,
        output o_busy, o_done, o_found, o_preimage, o_count
    );

    modport master (
        output i_start, i_target, i_rule,
        input  o_busy, o_done, o_found, o_preimage, o_count
    );
endinterface

// File: rtl/ca2_preimage_finder.sv
// Exhaustive preimage search for the 8-cell circular CA step Y[i] = rule[{A[i+1], A[i]}].
// Optional macro CA2_EARLY_EXIT_EN: stop at the first match (count becomes 0 or 1).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results from the last search are held
// SCAN  | one candidate evaluated per cycle, accumulators updated
// DONE  | one-cycle done pulse; results already loaded and valid
module ca2_preimage_finder #(
    parameter int N_CELLS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    ca2_preimage_finder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [N_CELLS-1:0] r_cand;
    logic [N_CELLS-1:0] r_target;
    logic [3:0]         r_rule;
    logic [N_CELLS:0]   r_acc_cnt;
    logic               r_acc_found;
    logic [N_CELLS-1:0] r_acc_pre;
    logic               r_found;
    logic [N_CELLS-1:0] r_preimage;
    logic [N_CELLS:0]   r_count;

    logic [N_CELLS-1:0] w_fwd;
    logic               w_match;
    logic               w_cand_max;
    logic               w_last;
    logic [N_CELLS:0]   w_cnt_nxt;
    logic               w_found_nxt;
    logic [N_CELLS-1:0] w_pre_nxt;
    logic               w_busy;
    logic               w_done;

    // Cell N_CELLS-1 takes cell 0 as its left neighbour.
    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            w_fwd[i] = r_rule[{r_cand[(i + 1) % N_CELLS], r_cand[i]}];
        end
    end

    assign w_match     = (w_fwd == r_target);
    assign w_cand_max  = &r_cand;
    assign w_cnt_nxt   = r_acc_cnt + {{N_CELLS{1'b0}}, w_match};
    assign w_found_nxt = r_acc_found | w_match;
    assign w_pre_nxt   = (!r_acc_found && w_match) ? r_cand : r_acc_pre;

`ifdef CA2_EARLY_EXIT_EN
    assign w_last = w_match | w_cand_max;
`else
    assign w_last = w_cand_max;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Results are loaded on the edge leaving SCAN so they are valid during DONE.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cand      <= '0;
            r_target    <= '0;
            r_rule      <= '0;
            r_acc_cnt   <= '0;
            r_acc_found <= 1'b0;
            r_acc_pre   <= '0;
            r_found     <= 1'b0;
            r_preimage  <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_target    <= bus.i_target;
                        r_rule      <= bus.i_rule;
                        r_cand      <= '0;
                        r_acc_cnt   <= '0;
                        r_acc_found <= 1'b0;
                        r_acc_pre   <= '0;
                    end
                end
                S_SCAN: begin
                    r_acc_cnt   <= w_cnt_nxt;
                    r_acc_found <= w_found_nxt;
                    r_acc_pre   <= w_pre_nxt;
                    if (w_last) begin
                        r_found    <= w_found_nxt;
                        r_preimage <= w_pre_nxt;
                        r_count    <= w_cnt_nxt;
                    end else begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_busy     = w_busy;
    assign bus.o_done     = w_done;
    assign bus.o_found    = r_found;
    assign bus.o_preimage = r_preimage;
    assign bus.o_count    = r_count;

endmodule

// File: tb/tb_ca2_preimage_finder.sv
// Self-checking bench for ca2_preimage_finder: directed plan cases plus random
// searches compared against an exhaustive arithmetic reference of the CA step.
module tb_ca2_preimage_finder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ca2_preimage_finder_if #(.N_CELLS(8)) u_if ();

    ca2_preimage_finder #(.N_CELLS(8)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (u_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic       prev_found;
    logic [7:0] prev_pre;
    logic [8:0] prev_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Neighbourhood of cell i is {A[(i+1)%8], A[i]}; rotating A right gives the left bits.
    function automatic logic [7:0] ca_step(input logic [7:0] a, input logic [3:0] rule);
        logic [7:0] left;
        logic [7:0] y;
        left = {a[0], a[7:1]};
        y = '0;
        for (int i = 0; i < 8; i++) y[i] = rule[{left[i], a[i]}];
        return y;
    endfunction

    task automatic model(input logic [7:0] t, input logic [3:0] r,
                         output logic f, output logic [7:0] p, output logic [8:0] c,
                         output int lat);
        f = 1'b0; p = '0; c = '0;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            if (ca_step(av, r) == t) begin
                if (!f) begin f = 1'b1; p = av; end
                c = c + 9'd1;
            end
        end
`ifdef CA2_EARLY_EXIT_EN
        lat = f ? int'(p) + 2 : 257;
        c   = f ? 9'd1 : 9'd0;
`else
        lat = 257;
`endif
    endtask

    // dup_at > 0: pulse start in that cycle; dup_at == 0: pulse start in the done cycle.
    task automatic search(input string tag, input logic [7:0] t, input logic [3:0] r,
                          input int dup_at);
        logic       ef;
        logic [7:0] ep;
        logic [8:0] ec;
        int         elat;
        int         first_done;
        int         n_done;
        logic       cf;
        logic [7:0] cp;
        logic [8:0] cc;
        logic       busy_after;
        model(t, r, ef, ep, ec, elat);
        cf = 1'bx; cp = 'x; cc = 'x; busy_after = 1'bx;
        @(negedge clk);
        u_if.i_start = 1'b1; u_if.i_target = t; u_if.i_rule = r;
        @(negedge clk);
        u_if.i_start = 1'b0; u_if.i_target = ~t; u_if.i_rule = ~r;
        check({tag, "_busy_scan"}, 32'(u_if.o_busy), 32'd1);
        check({tag, "_hold_found"}, 32'(u_if.o_found), 32'(prev_found));
        check({tag, "_hold_pre"}, 32'(u_if.o_preimage), 32'(prev_pre));
        check({tag, "_hold_cnt"}, 32'(u_if.o_count), 32'(prev_cnt));
        first_done = 0;
        n_done = 0;
        for (int cyc = 1; cyc <= 275; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (u_if.o_done === 1'b1) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = cyc;
                    cf = u_if.o_found; cp = u_if.o_preimage; cc = u_if.o_count;
                end
            end
            if (first_done != 0 && cyc == first_done + 1) busy_after = u_if.o_busy;
            u_if.i_start = (cyc == dup_at) || (dup_at == 0 && u_if.o_done === 1'b1);
            if (first_done != 0 && cyc == first_done + 3) break;
        end
        u_if.i_start = 1'b0;
        check({tag, "_latency"}, 32'(first_done), 32'(elat));
        check({tag, "_ndone"}, 32'(n_done), 32'd1);
        check({tag, "_found"}, 32'(cf), 32'(ef));
        check({tag, "_pre"}, 32'(cp), 32'(ep));
        check({tag, "_count"}, 32'(cc), 32'(ec));
        check({tag, "_busy_idle"}, 32'(busy_after), 32'd0);
        prev_found = ef; prev_pre = ep; prev_cnt = ec;
    endtask

    initial begin
        int n_done;
        logic [7:0] rt;
        logic [3:0] rr;

        rst_n = 1'b0;
        u_if.i_start = 1'b0; u_if.i_target = '0; u_if.i_rule = '0;
        prev_found = 1'b0; prev_pre = '0; prev_cnt = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(u_if.o_busy), 32'd0);
        check("rst_done", 32'(u_if.o_done), 32'd0);
        check("rst_found", 32'(u_if.o_found), 32'd0);
        check("rst_pre", 32'(u_if.o_preimage), 32'd0);
        check("rst_cnt", 32'(u_if.o_count), 32'd0);
        rst_n = 1'b1;

        search("ident_5a", 8'h5A, 4'b1010, -1);
        search("shift_01", 8'h01, 4'b1100, -1);
        search("xor_00", 8'h00, 4'b0110, -1);
        search("xor_01", 8'h01, 4'b0110, -1);
        search("zero_00", 8'h00, 4'b0000, -1);
        search("zero_ff", 8'hFF, 4'b0000, -1);
        search("dup_start", 8'h5A, 4'b1010, 100);
        search("start_in_done", 8'h3C, 4'b1100, 0);

        // Abort a running search with reset at cycle 50.
        @(negedge clk);
        u_if.i_start = 1'b1; u_if.i_target = 8'h00; u_if.i_rule = 4'b0110;
        @(negedge clk);
        u_if.i_start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(u_if.o_busy), 32'd0);
        check("abort_done", 32'(u_if.o_done), 32'd0);
        check("abort_found", 32'(u_if.o_found), 32'd0);
        check("abort_pre", 32'(u_if.o_preimage), 32'd0);
        check("abort_cnt", 32'(u_if.o_count), 32'd0);
        rst_n = 1'b1;
        prev_found = 1'b0; prev_pre = '0; prev_cnt = '0;
        n_done = 0;
        repeat (270) begin
            @(negedge clk);
            if (u_if.o_done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        search("after_abort", 8'h5A, 4'b1010, -1);

        for (int k = 0; k < 6; k++) begin
            rr = 4'($urandom_range(0, 15));
            rt = 8'($urandom_range(0, 255));
            if (k % 2 == 0) rt = ca_step(rt, rr);
            search($sformatf("rand%0d", k), rt, rr, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ca2_preimage_finder.md
Name: ca2_preimage_finder

Overview:
- Inverse companion to the 8-cell, 4-entry-rule circular cellular-automaton step used in the datapath.
- Forward step: Y[i] = rule[{A[(i+1)%8], A[i]}].
- Given a target next-state and a rule, the block sequentially searches all 256 candidate current-states and finds every A that maps to the target.
- Reports the lowest matching A and the total number of matches.
- Sits beside the forward step as a multi-cycle coprocessor with a start/done handshake.

Parameters:
- N_CELLS, 8, ring width; must be 8 in this revision; only 8 is verified.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge; 0 = reset
- start  in  1  request a search; honoured only in IDLE
- target  in  8  next-state whose preimages are searched; latched on accepted start
- rule  in  4  rule table, rule[k] = output bit for neighbourhood k = {left,self}; latched on accepted start
- busy  out  1  high in SCAN and DONE
- done  out  1  single-cycle pulse when results are valid
- found  out  1  at least one preimage exists
- preimage  out  8  lowest-valued matching A; 0 if none
- count  out  9  number of matching A, range 0..256

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; busy=0, done=0, found=0, preimage=0, count=0; internal candidate, accumulators and latched target/rule cleared. Reset mid-SCAN aborts with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start==1 -> latch target/rule, cand=0, acc_cnt=0, acc_found=0, acc_pre=0; go to SCAN.
  - start==0 -> stay in IDLE.
- SCAN: each cycle evaluates one candidate.
  - Compute f(cand) combinationally with circular wrap: cell 7's left neighbour is cell 0.
  - If f(cand)==latched target:
    - acc_cnt += 1.
    - If acc_found==0: set acc_found=1 and acc_pre=cand.
  - If cand==255 -> go to DONE; otherwise cand += 1. The 8-bit cand never wraps during a search.
- DONE (one cycle):
  - done=1.
  - found/preimage/count load from the accumulators, including the candidate-255 update.
  - Next state is IDLE.
- Timing:
  - start accepted at edge 0; candidates 0..255 are evaluated in cycles 1..256; done is high in cycle 257.
  - Fixed latency: 257 cycles from accepted start to the done cycle.
- Output stability:
  - found/preimage/count change only in the DONE cycle or on reset.
  - They hold their values through the following IDLE and through the next SCAN.
- busy: 1 in SCAN and DONE, 0 in IDLE.
- start is ignored while busy; no queuing. start in the DONE cycle is ignored; a new start is accepted one cycle later, in IDLE.
- Changes on target/rule after acceptance have no effect on the running search.
- count saturation is not needed: the maximum is 256, which fits in 9 bits. 256 occurs for a constant rule when the target is all-0s or all-1s.

Optional Feature:
- Macro: CA2_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE on the first match, or after candidate 255 if there is no match.
  - count is then 1 if found, else 0.
  - Latency is (first match value + 2) cycles, or 257 if no match.
- Undefined: full 256-candidate scan with an exact count, as described above.

Test Plan:
- rule=4'b1010 (identity), target=8'h5A -> done at cycle 257, found=1, preimage=8'h5A, count=1.
- rule=4'b1100 (Y[i]=A[i+1]), target=8'h01 -> found=1, preimage=8'h02, count=1.
- rule=4'b0110 (XOR):
  - target=8'h00 -> found=1, preimage=8'h00, count=2 (00, FF).
  - target=8'h01 (odd parity) -> found=0, preimage=8'h00, count=0.
- rule=4'b0000:
  - target=8'h00 -> count=256, preimage=8'h00, found=1.
  - target=8'hFF -> count=0, found=0.
- Reset and handshake:
  - Pulse start again at cycle 100 of a search -> ignored; exactly one done at cycle 257.
  - reset=0 at cycle 50 of a search -> busy=0, outputs=0, no done; a fresh start afterwards completes normally.
- With CA2_EARLY_EXIT_EN, rule=4'b0000, target=8'h00 -> done at cycle 2, found=1, preimage=8'h00, count=1.
